// File: rtl/denise_pkg.sv
// Shared Denise definitions: bitplane geometry, BPLxDAT register offsets and
// the small scroll/plane-count helpers used by the bitplane serialiser.
package denise_pkg;

  localparam int BPL_PLANES = 6;
  localparam int BPL_DW     = 16;

  typedef logic [15:0] bpl_word_t;

  localparam logic [2:0] BPL1DAT = 3'd0;
  localparam logic [2:0] BPL2DAT = 3'd1;
  localparam logic [2:0] BPL3DAT = 3'd2;
  localparam logic [2:0] BPL4DAT = 3'd3;
  localparam logic [2:0] BPL5DAT = 3'd4;
  localparam logic [2:0] BPL6DAT = 3'd5;

  // Scroll is in lores pixels; the counter runs in hires slots, and hires
  // only honours the low three scroll bits.
  function automatic logic [4:0] scroll_delay(input logic [3:0] scroll, input logic hires);
    return hires ? {1'b0, scroll[2:0], 1'b0} : {scroll, 1'b0};
  endfunction

  function automatic logic [2:0] bpu_limit(input logic [2:0] bpu, input logic hires);
    logic [2:0] lim;
    lim = hires ? 3'd4 : 3'd6;
    return (bpu > lim) ? lim : bpu;
  endfunction

endpackage

// File: rtl/denise_bpl_lane.sv
// One bitplane lane: BPLxDAT holding register, pending word and the MSB-first
// shifter, driven by load/shift strobes from the group controller.
module denise_bpl_lane #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr,
  input  logic [DW-1:0] wr_data,
  input  logic          pend_load,
  input  logic          flush,
  input  logic          direct,
  input  logic          step,
  output logic          msb_next
);

  logic [DW-1:0] hold;
  logic [DW-1:0] pend;
  logic [DW-1:0] shift;
  logic [DW-1:0] new_word;
  logic [DW-1:0] shift_nx;

  // A write landing on the trigger clk must reach pend/shift in that same clk.
  always_comb begin
    new_word = wr ? wr_data : hold;
    if (direct) begin
      shift_nx = new_word;
    end else if (flush) begin
      shift_nx = pend;
    end else if (step) begin
      shift_nx = {shift[DW-2:0], 1'b0};
    end else begin
      shift_nx = shift;
    end
    msb_next = shift_nx[DW-1];
  end

  // Lane storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold  <= '0;
      pend  <= '0;
      shift <= '0;
    end else begin
      if (wr) begin
        hold <= wr_data;
      end
      if (pend_load) begin
        pend <= new_word;
      end
      shift <= shift_nx;
    end
  end

endmodule

// File: rtl/denise_bpl_shifter.sv
// Denise bitplane serialiser: per-playfield scroll-delayed parallel load and
// lores/hires MSB-first shifting of up to six planes onto bpl_bus.
module denise_bpl_shifter
  import denise_pkg::*;
#(
  parameter int PLANES = BPL_PLANES,
  parameter int DW     = BPL_DW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_ce,
  input  logic              hires,
  input  logic [2:0]        bpu,
  input  logic              wr_en,
  input  logic [2:0]        wr_idx,
  input  logic [DW-1:0]     wr_data,
  input  logic [3:0]        pf1_scroll,
  input  logic [3:0]        pf2_scroll,
  output logic [PLANES-1:0] bpl_bus
);

  logic              trig;
  logic [1:0][3:0]   scroll;
  logic [1:0][4:0]   dly;
  logic [1:0][4:0]   cnt;
  logic [1:0][4:0]   cnt_nx;
  logic [1:0]        armed;
  logic [1:0]        armed_nx;
  logic [1:0]        ph;
  logic [1:0]        ph_nx;
  logic [1:0]        pend_load;
  logic [1:0]        flush;
  logic [1:0]        direct;
  logic [1:0]        step;
  logic [2:0]        bpu_eff;
  logic [PLANES-1:0] mask;
  logic [PLANES-1:0] msb_next;

  // Group 0 is playfield 1 (odd planes), group 1 is playfield 2 (even planes).
  always_comb begin
    trig      = wr_en && (wr_idx == BPL1DAT);
    scroll    = {pf2_scroll, pf1_scroll};
    cnt_nx    = cnt;
    armed_nx  = armed;
    ph_nx     = ph;
    pend_load = 2'b00;
    flush     = 2'b00;
    direct    = 2'b00;
    step      = 2'b00;
    for (int g = 0; g < 2; g++) begin
      dly[g] = scroll_delay(scroll[g], hires);
      if (trig) begin
        if (pix_ce && (dly[g] == 5'd0)) begin
          direct[g]   = 1'b1;
          armed_nx[g] = 1'b0;
          ph_nx[g]    = 1'b0;
          cnt_nx[g]   = 5'd0;
        end else begin
          // A load still outstanding is flushed into the shifter right now.
          pend_load[g] = 1'b1;
          armed_nx[g]  = 1'b1;
          cnt_nx[g]    = pix_ce ? (dly[g] - 5'd1) : dly[g];
          if (armed[g]) begin
            flush[g] = 1'b1;
            ph_nx[g] = 1'b0;
          end else if (pix_ce) begin
            step[g]  = hires | ph[g];
            ph_nx[g] = ~ph[g];
          end else begin
            ph_nx[g] = ph[g];
          end
        end
      end else if (pix_ce) begin
        if (armed[g] && (cnt[g] == 5'd0)) begin
          flush[g]    = 1'b1;
          armed_nx[g] = 1'b0;
          ph_nx[g]    = 1'b0;
        end else begin
          if (armed[g]) begin
            cnt_nx[g] = cnt[g] - 5'd1;
          end else begin
            cnt_nx[g] = cnt[g];
          end
          step[g]  = hires | ph[g];
          ph_nx[g] = ~ph[g];
        end
      end else begin
        ph_nx[g] = ph[g];
      end
    end
  end

  // Group controller state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      armed <= 2'b00;
      ph    <= 2'b00;
    end else begin
      cnt   <= cnt_nx;
      armed <= armed_nx;
      ph    <= ph_nx;
    end
  end

  for (genvar i = 0; i < PLANES; i++) begin : g_lane
    denise_bpl_lane #(.DW(DW)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr        (wr_en && (wr_idx == 3'(i))),
      .wr_data   (wr_data),
      .pend_load (pend_load[i % 2]),
      .flush     (flush[i % 2]),
      .direct    (direct[i % 2]),
      .step      (step[i % 2]),
      .msb_next  (msb_next[i])
    );
  end

  // OCS caps hires at four planes.
  always_comb begin
    bpu_eff = bpu_limit(bpu, hires);
    for (int i = 0; i < PLANES; i++) begin
      mask[i] = (3'(i) < bpu_eff);
    end
  end

  // Output register follows the post-update shifter MSBs on pixel slots only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bpl_bus <= '0;
    end else if (pix_ce) begin
      bpl_bus <= msb_next & mask;
    end else begin
      bpl_bus <= bpl_bus;
    end
  end

endmodule

// File: tb/tb_denise_bpl_shifter.sv
// Self-checking bench for denise_bpl_shifter: directed scenarios plus random
// stimulus against a pixel-index reference model.
module tb_denise_bpl_shifter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pix_ce;
  logic        hires;
  logic [2:0]  bpu;
  logic        wr_en;
  logic [2:0]  wr_idx;
  logic [15:0] wr_data;
  logic [3:0]  pf1_scroll;
  logic [3:0]  pf2_scroll;
  logic [5:0]  bpl_bus;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  denise_bpl_shifter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_ce     (pix_ce),
    .hires      (hires),
    .bpu        (bpu),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_data    (wr_data),
    .pf1_scroll (pf1_scroll),
    .pf2_scroll (pf2_scroll),
    .bpl_bus    (bpl_bus)
  );

  // Reference model: each group remembers the word loaded into the shifter
  // and how many slots have elapsed since; the visible bit is found by index.
  logic [15:0] m_hold [6];
  logic [15:0] m_pend [6];
  logic [15:0] m_cur  [6];
  bit          m_armed [2];
  int          m_d [2];
  int          m_n [2];
  logic [5:0]  m_bus;

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin
      m_hold[i] = 16'h0; m_pend[i] = 16'h0; m_cur[i] = 16'h0;
    end
    for (int g = 0; g < 2; g++) begin
      m_armed[g] = 0; m_d[g] = 0; m_n[g] = 64;
    end
    m_bus = 6'h0;
  endtask

  task automatic model_clk();
    bit trig;
    bit loaded;
    int sc, dl, lim, eff, pos;
    trig = wr_en && (wr_idx == 3'd0);
    if (wr_en && (wr_idx < 3'd6)) m_hold[wr_idx] = wr_data;
    for (int g = 0; g < 2; g++) begin
      loaded = 0;
      sc = (g == 0) ? int'(pf1_scroll) : int'(pf2_scroll);
      dl = hires ? 2 * (sc % 8) : 2 * sc;
      if (trig) begin
        if (m_armed[g]) begin
          for (int i = g; i < 6; i += 2) m_cur[i] = m_pend[i];
          m_n[g] = 0; loaded = 1;
        end
        for (int i = g; i < 6; i += 2) m_pend[i] = m_hold[i];
        m_d[g] = dl; m_armed[g] = 1;
      end
      if (pix_ce && m_armed[g]) begin
        if (m_d[g] == 0) begin
          for (int i = g; i < 6; i += 2) m_cur[i] = m_pend[i];
          m_n[g] = 0; loaded = 1; m_armed[g] = 0;
        end else begin
          m_d[g]--;
        end
      end
      if (pix_ce && !loaded && m_n[g] < 64) m_n[g]++;
    end
    if (pix_ce) begin
      lim = hires ? 4 : 6;
      eff = (int'(bpu) > lim) ? lim : int'(bpu);
      for (int i = 0; i < 6; i++) begin
        pos = hires ? m_n[i % 2] : m_n[i % 2] / 2;
        m_bus[i] = (i < eff && pos < 16) ? m_cur[i][15 - pos] : 1'b0;
      end
    end
  endtask

  task automatic tick(input bit pce, input bit we, input logic [2:0] idx, input logic [15:0] d);
    @(negedge clk);
    pix_ce = pce; wr_en = we; wr_idx = idx; wr_data = d;
    @(posedge clk);
    model_clk();
    #1;
    pix_ce = 1'b0; wr_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    pix_ce = 1'b0; wr_en = 1'b0; wr_idx = 3'd0; wr_data = 16'h0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    hires = 1'b0; bpu = 3'd6; pf1_scroll = 4'd0; pf2_scroll = 4'd0;
    do_reset();
    tests++;
    if (bpl_bus !== 6'h00) begin
      fails++; $display("FAIL reset_state: got %h expected %h", bpl_bus, 6'h00);
    end
  endtask

  task automatic test_lores_basic();
    bit exp;
    do_reset();
    hires = 1'b0; bpu = 3'd1; pf1_scroll = 4'd0; pf2_scroll = 4'd0;
    for (int k = 0; k < 40; k++) begin
      tick(1'b1, k == 0, 3'd0, 16'h8001);
      exp = (k < 2) || (k == 30) || (k == 31);
      tests++;
      if (bpl_bus !== {5'b0, exp}) begin
        fails++; $display("FAIL lores_slot%0d: got %h expected %h", k, bpl_bus, {5'b0, exp});
      end
      tests++;
      if (bpl_bus !== m_bus) begin
        fails++; $display("FAIL lores_model%0d: got %h expected %h", k, bpl_bus, m_bus);
      end
      tick(1'b0, 1'b0, 3'd0, 16'h0);
    end
  endtask

  task automatic test_hires_planes();
    logic [5:0] exp;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      hires = 1'b1; bpu = (pass == 0) ? 3'd4 : 3'd6;
      pf1_scroll = 4'd0; pf2_scroll = 4'd0;
      for (int i = 1; i < 6; i++) tick(1'b0, 1'b1, 3'(i), 16'hFFFF);
      for (int k = 0; k < 20; k++) begin
        tick(1'b1, k == 0, 3'd0, 16'hAAAA);
        exp = (k >= 16) ? 6'h00 : ((k % 2 == 0) ? 6'h0F : 6'h0E);
        tests++;
        if (bpl_bus !== exp) begin
          fails++; $display("FAIL hires_bpu%0d_slot%0d: got %h expected %h", bpu, k, bpl_bus, exp);
        end
        tests++;
        if (bpl_bus !== m_bus) begin
          fails++; $display("FAIL hires_model%0d: got %h expected %h", k, bpl_bus, m_bus);
        end
      end
    end
  endtask

  task automatic test_scroll_split();
    logic [5:0] exp;
    do_reset();
    hires = 1'b0; bpu = 3'd2; pf1_scroll = 4'd3; pf2_scroll = 4'd0;
    tick(1'b0, 1'b1, 3'd1, 16'h8000);
    for (int k = 0; k < 16; k++) begin
      tick(1'b1, k == 0, 3'd0, 16'h8000);
      exp = {4'b0, (k < 2), (k == 6 || k == 7)};
      tests++;
      if (bpl_bus !== exp) begin
        fails++; $display("FAIL scroll_slot%0d: got %h expected %h", k, bpl_bus, exp);
      end
      tests++;
      if (bpl_bus !== m_bus) begin
        fails++; $display("FAIL scroll_model%0d: got %h expected %h", k, bpl_bus, m_bus);
      end
      tick(1'b0, 1'b0, 3'd0, 16'h0);
    end
  endtask

  task automatic test_retrigger();
    logic [15:0] w1, w2;
    do_reset();
    hires = 1'b0; bpu = 3'd6; pf1_scroll = 4'd15; pf2_scroll = 4'd15;
    w1 = 16'($urandom) | 16'h8000;
    w2 = 16'($urandom) | 16'h8000;
    for (int i = 1; i < 6; i++) tick(1'b0, 1'b1, 3'(i), 16'($urandom));
    for (int k = 0; k < 60; k++) begin
      if (k == 10) for (int i = 1; i < 6; i++) tick(1'b0, 1'b1, 3'(i), 16'($urandom));
      tick(1'b1, (k == 0) || (k == 10), 3'd0, (k == 0) ? w1 : w2);
      tests++;
      if (bpl_bus !== m_bus) begin
        fails++; $display("FAIL retrig_model%0d: got %h expected %h", k, bpl_bus, m_bus);
      end
      if (k == 10 || k == 40) begin
        tests++;
        if (bpl_bus[0] !== 1'b1) begin
          fails++; $display("FAIL retrig_load_slot%0d: got %b expected 1", k, bpl_bus[0]);
        end
      end
      tick(1'b0, 1'b0, 3'd0, 16'h0);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    hires = 1'b0; bpu = 3'd6; pf1_scroll = 4'd0; pf2_scroll = 4'd0;
    for (int i = 1; i < 6; i++) tick(1'b0, 1'b1, 3'(i), 16'hFFFF);
    tick(1'b1, 1'b1, 3'd0, 16'hFFFF);
    tick(1'b1, 1'b0, 3'd0, 16'h0);
    tests++;
    if (bpl_bus !== 6'h3F) begin
      fails++; $display("FAIL async_pre: got %h expected %h", bpl_bus, 6'h3F);
    end
    pf1_scroll = 4'd5; pf2_scroll = 4'd2;
    tick(1'b0, 1'b1, 3'd0, 16'hFFFF);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (bpl_bus !== 6'h00) begin
      fails++; $display("FAIL async_clear: got %h expected %h", bpl_bus, 6'h00);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick(1'b1, 1'b0, 3'd0, 16'h0);
      tests++;
      if (bpl_bus !== 6'h00) begin
        fails++; $display("FAIL async_noload%0d: got %h expected %h", k, bpl_bus, 6'h00);
      end
    end
  endtask

  task automatic test_ignored_idx();
    do_reset();
    hires = 1'b0; bpu = 3'd6; pf1_scroll = 4'd0; pf2_scroll = 4'd0;
    for (int i = 1; i < 6; i++) tick(1'b0, 1'b1, 3'(i), 16'h0000);
    for (int k = 0; k < 8; k++) begin
      tick(1'b1, 1'b1, (k % 2 == 0) ? 3'd6 : 3'd7, 16'hFFFF);
      tests++;
      if (bpl_bus !== 6'h00) begin
        fails++; $display("FAIL ignored_notrig%0d: got %h expected %h", k, bpl_bus, 6'h00);
      end
    end
    for (int k = 0; k < 6; k++) begin
      tick(1'b1, k == 0, 3'd0, 16'h0000);
      tests++;
      if (bpl_bus !== 6'h00 || bpl_bus !== m_bus) begin
        fails++; $display("FAIL ignored_hold%0d: got %h expected %h", k, bpl_bus, 6'h00);
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 2; r++) begin
      do_reset();
      hires = r[0]; bpu = 3'($urandom_range(0, 7));
      pf1_scroll = 4'($urandom); pf2_scroll = 4'($urandom);
      for (int k = 0; k < 600; k++) begin
        if ($urandom_range(0, 19) == 0) bpu = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 9) == 0) pf1_scroll = 4'($urandom);
        if ($urandom_range(0, 9) == 0) pf2_scroll = 4'($urandom);
        tick($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
             3'($urandom_range(0, 7)), 16'($urandom));
        tests++;
        if (bpl_bus !== m_bus) begin
          fails++; $display("FAIL random_h%0d_clk%0d: got %h expected %h", r, k, bpl_bus, m_bus);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; pix_ce = 1'b0; wr_en = 1'b0; wr_idx = 3'd0; wr_data = 16'h0;
    hires = 1'b0; bpu = 3'd0; pf1_scroll = 4'd0; pf2_scroll = 4'd0;
    model_reset();
    test_reset();
    test_lores_basic();
    test_hires_planes();
    test_scroll_split();
    test_retrigger();
    test_async_reset();
    test_ignored_idx();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/denise_bpl_shifter.md
# denise_bpl_shifter

Bitplane serialiser for the Denise core. It captures the BPLxDAT words written over the register bus, delays their parallel load per playfield by the BPLCON1 scroll values, and shifts them out MSB-first at lores or hires rate. The output is the 6-bit `bpl_bus`, which feeds the playfield/priority stage that forms the CLUT index for `denise_clut`.

## Interface
Parameters:
- `PLANES`, default 6: number of bitplane lanes.
- `DW`, default 16: bitplane data word width.

Ports:
- `clk` in 1: core clock; every register in the block is clocked by it.
- `rst_n` in 1: reset, asynchronous and active-low.
- `pix_ce` in 1: one-`clk` enable per hires pixel slot.
- `hires` in 1: BPLCON0 HIRES.
- `bpu` in 3: BPLCON0 BPU, the number of active planes.
- `wr_en` in 1: single-`clk` write strobe for a BPLxDAT register.
- `wr_idx` in 3: target plane. 0 is BPL1DAT, 5 is BPL6DAT. Values 6 and 7 are ignored.
- `wr_data` in 16: write data.
- `pf1_scroll` in 4: BPLCON1 PF1H; delays the odd planes 1, 3, 5 (idx 0, 2, 4).
- `pf2_scroll` in 4: BPLCON1 PF2H; delays the even planes 2, 4, 6 (idx 1, 3, 5).
- `bpl_bus` out 6: registered pixel bits. Bit i is the output of plane i+1.

## Operation
- **Holding registers.** There are 6×16 holding registers. `wr_en` writes `hold[wr_idx]`.
- **Load trigger.** A write with `wr_idx==0` (BPL1DAT) is the load trigger, exactly as in real Denise.
  - In the same `clk`, all 6 lanes copy hold→pend. For lane 0, pend receives `wr_data` directly.
  - Both playfield groups are armed with delay counters. Delay in slots: lores = `2*scroll`, hires = `2*scroll[2:0]`. Range 0..30.
  - The scroll value is sampled at trigger time. Later BPLCON1 changes do not affect an armed load.
- **Per `pix_ce`, per group, when armed:**
  - If `cnt==0`: pend→shift, disarm, `ph:=0`. No shift in this slot.
  - Otherwise: `cnt--`, then apply the normal shift rule below.
- **Normal shift rule** (applies on every `pix_ce` that is not a load slot for the group):
  - If `hires || ph`, shift the group's lanes left by 1 with 0 fill.
  - In all such slots, `ph:=~ph`.
  - Result: each lores pixel is held for 2 slots and each hires pixel for 1 slot.
- **Re-trigger while armed.** On the trigger `clk`, the outstanding pend→shift of the armed group happens immediately (`ph:=0`). Then the new hold→pend copy and re-arm proceed. No data is lost.
- **Output enable.** `bpl_bus[i] = shift[i][15] & (i < bpu_eff)`.
  - `bpu_eff = min(bpu,6)`.
  - In hires, `bpu_eff = min(bpu,4)` (OCS limit).
- **Idle.** Shifters that are never loaded drain to 0 after 16 pixels.

## Timing
- **Reset.** All hold, pend and shift registers are 0. Counters are 0, armed is 0, `ph` is 0. `bpl_bus = 6'b0`.
- **Reset mid-operation.** Assertion of `rst_n` aborts any armed load immediately and asynchronously.
- **Output update.** `bpl_bus` is a register updated only on `pix_ce` `clk`s. It shows the post-update shifter MSBs one `clk` after that edge.
- **Latency.**
  - Delay 0: the first `pix_ce` at or after the trigger `clk` loads, and bit 15 appears on `bpl_bus` the next `clk`.
  - Delay N: the load happens on the (N+1)th `pix_ce`.
- **`pix_ce` and trigger in the same `clk`.** The trigger arms first. That `pix_ce` counts as the first slot.
- **`bpu`/`hires` changes.** These are combinational on masking and sampled per slot. They take effect on the next `pix_ce`.
- **Throughput.** The block accepts one write per `clk`. It has no back-pressure.

## Structure
- **Shared package `denise_pkg`:**
  - `BPL_PLANES=6`, `BPL_DW=16`.
  - `typedef logic [15:0] bpl_word_t`.
  - Register offsets `BPL1DAT`..`BPL6DAT`, so the register-bus decoder produces `wr_idx`.
- **Sub-module `denise_bpl_lane`:** one plane's hold, pend and 16-bit shifter. It takes `load`/`shift` strobes from the parent.
- **The parent contains:** two group controllers (counter, armed, `ph`), the `bpu` mask, and the output register.

## Test plan
- **Lores, no scroll.** `hires=0`, `bpu=1`, scroll 0. Write BPL1DAT=0x8001 with `pix_ce` every 2nd `clk`. Required: `bpl_bus[0]=1` for 2 slots, 0 for 28 slots, 1 for 2 slots, then 0.
- **Hires, 4 planes.** `hires=1`, `bpu=4`. Write hold 1..3 = 0xFFFF, then BPL1DAT=0xAAAA. Required: `bpl_bus` alternates 0xF/0xE each slot for 16 slots. `bpu=6` in hires keeps bits 5:4 = 0.
- **Scroll split.** `pf1_scroll=3`, `pf2_scroll=0`, lores, `bpu=2`, both words 0x8000. Required: plane 2 shows 1 at slots 0-1 and plane 1 shows 1 at slots 6-7.
- **Re-trigger while armed.** Scroll 15. A second BPL1DAT write at slot 10 of the first load. Required: first word loaded on that `clk`, second word appears 30 slots later, no bits dropped.
- **Async reset.** Assert `rst_n=0` mid-shift with `bpl_bus=0x3F`. Required: `bpl_bus=0` without a clock edge, and no load after release.
- **Ignored index.** Write with `wr_idx=6`/`7`. Required: no holding-register change and no trigger.
